// File: rtl/inst_buffer_queue_pkg.sv
// Shared types and constants for the decode-to-rename instruction buffer.
// DISPATCH_WIDTH may be set on the command line; it defaults to 4 lanes.
`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 4
`endif

package inst_buffer_queue_pkg;

  localparam int DISPATCH_W  = `DISPATCH_WIDTH;
  localparam int IBUFF_DEPTH = 32;
  localparam int IBUFF_AW    = $clog2(IBUFF_DEPTH);

  // One decoded packet as handed from decode to rename. The buffer only
  // moves these around; it never looks inside apart from the valid bit.
  typedef struct packed {
    logic        valid;
    logic [7:0]  seq_no;
    logic [31:0] pc;
  } ren_pkt_t;

  localparam int PKT_W = $bits(ren_pkt_t);

  // Event counter increment that sticks at all-ones.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    sat_inc32 = (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/inst_buffer_queue_ibuff_ram.sv
// Storage array for the instruction buffer: W synchronous write ports,
// W asynchronous read ports. Write addresses within one cycle are distinct
// (consecutive ring slots), so port order does not matter.
module ibuff_ram
  import inst_buffer_queue_pkg::*;
#(
  parameter int W     = DISPATCH_W,
  parameter int DEPTH = IBUFF_DEPTH,
  parameter int AW    = IBUFF_AW
) (
  input  logic                       clk,
  input  logic [W-1:0]               we_i,
  input  logic [W-1:0][AW-1:0]       waddr_i,
  input  ren_pkt_t [W-1:0]           wdata_i,
  input  logic [W-1:0][AW-1:0]       raddr_i,
  output ren_pkt_t [W-1:0]           rdata_o
);

  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [PKT_W-1:0] mem_d [DEPTH];

  // Merge this cycle's lane writes into the array image.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < W; i++) begin
      if (we_i[i]) begin
        mem_d[waddr_i[i]] = wdata_i[i];
      end
    end
  end

  // Storage register; contents need no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Asynchronous read of W consecutive slots.
  always_comb begin
    for (int i = 0; i < W; i++) begin
      rdata_o[i] = ren_pkt_t'(mem_q[raddr_i[i]]);
    end
  end

endmodule

// File: rtl/inst_buffer_queue.sv
// Decoupling FIFO between decode and rename.
// Optional macro IBUFF_PERF_EN adds fullCycles_o / starveCycles_o counters.
//
// Handshake: decode offers decValid_i (thermometer from lane 0) and the
// packets are taken whenever stallDecode_o is low; stallDecode_o comes from
// the registered count only, so a same-cycle pop never releases it. Rename
// takes W packets whenever instBufferReady_o is high and stall_i is low.
module inst_buffer_queue
  import inst_buffer_queue_pkg::*;
#(
  parameter int W     = DISPATCH_W,
  parameter int DEPTH = IBUFF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              recoverFlag_i,
  input  logic              stall_i,
  input  ren_pkt_t [W-1:0]  decPacket_i,
  input  logic [W-1:0]      decValid_i,
  output ren_pkt_t [W-1:0]  renPacket_o,
  output logic              instBufferReady_o,
  output logic              stallDecode_o,
  output logic [AW:0]       ibuffCnt_o
`ifdef IBUFF_PERF_EN
  ,
  output logic [31:0]       fullCycles_o,
  output logic [31:0]       starveCycles_o
`endif
);

  logic [AW-1:0]        head_q, head_d;
  logic [AW-1:0]        tail_q, tail_d;
  logic [AW:0]          count_q, count_d;
  logic                 ready;
  logic                 stall_dec;
  logic                 pop;
  logic                 push_en;
  logic [AW:0]          n_push;
  logic [W:0]           dv_ext;
  logic                 thermo_ok;
  logic [W-1:0]         ram_we;
  logic [W-1:0][AW-1:0] ram_waddr;
  logic [W-1:0][AW-1:0] ram_raddr;
  ren_pkt_t [W-1:0]     ram_rdata;

  // Status flags derived purely from the registered occupancy.
  always_comb begin
    ready     = (count_q >= (AW+1)'(W));
    stall_dec = (((AW+1)'(DEPTH) - count_q) < (AW+1)'(W));
  end

  // Lane accounting: only the number of valid lanes matters; recovery
  // discards any push or pop in the same cycle.
  always_comb begin
    n_push = '0;
    for (int i = 0; i < W; i++) begin
      if (decValid_i[i]) n_push = n_push + (AW+1)'(1);
    end
    dv_ext    = {1'b0, decValid_i};
    thermo_ok = ((dv_ext & (dv_ext + (W+1)'(1))) == '0);
    push_en   = ~stall_dec & ~recoverFlag_i;
    pop       = ready & ~stall_i & ~recoverFlag_i;
    for (int i = 0; i < W; i++) begin
      ram_we[i]    = push_en && ((AW+1)'(i) < n_push);
      ram_waddr[i] = tail_q + AW'(i);
      ram_raddr[i] = head_q + AW'(i);
    end
  end

  // Pointer and occupancy update; pointers wrap by truncation.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (recoverFlag_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) head_d = head_q + AW'(W);
      if (push_en) tail_d = tail_q + n_push[AW-1:0];
      count_d = count_q + (push_en ? n_push : '0) - (pop ? (AW+1)'(W) : '0);
    end
  end

  // Pointer and count registers; reset overrides recovery.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  ibuff_ram #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (decPacket_i),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Rename view: W slots from head, valid forced to the ready flag.
  always_comb begin
    for (int i = 0; i < W; i++) begin
      renPacket_o[i]       = ram_rdata[i];
      renPacket_o[i].valid = ready;
    end
  end

  assign instBufferReady_o = ready;
  assign stallDecode_o     = stall_dec;
  assign ibuffCnt_o        = count_q;

`ifdef IBUFF_PERF_EN
  logic [31:0] full_cycles_q, full_cycles_d;
  logic [31:0] starve_cycles_q, starve_cycles_d;

  // Saturating event counts; recovery leaves them alone.
  always_comb begin
    full_cycles_d   = sat_inc32(full_cycles_q, stall_dec);
    starve_cycles_d = sat_inc32(starve_cycles_q, ~ready & ~stall_i);
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_cycles_q   <= '0;
      starve_cycles_q <= '0;
    end else begin
      full_cycles_q   <= full_cycles_d;
      starve_cycles_q <= starve_cycles_d;
    end
  end

  assign fullCycles_o   = full_cycles_q;
  assign starveCycles_o = starve_cycles_q;
`else
  // Counters are not built; core behaviour is unchanged.
`endif

  // Decode must hold while stalled; writes in that cycle would be lost.
  a_no_write_when_stalled: assert property (@(posedge clk) disable iff (reset)
    !(stall_dec && (decValid_i != '0)));

  // Lane valids must be contiguous from lane 0.
  a_thermometer_valid: assert property (@(posedge clk) disable iff (reset)
    thermo_ok);

  // Occupancy stays within the array.
  a_count_in_range: assert property (@(posedge clk) disable iff (reset)
    count_q <= (AW+1)'(DEPTH));

endmodule

// File: tb/tb_inst_buffer_queue.sv
// Self-checking bench for inst_buffer_queue. Define IBUFF_PERF_EN to also
// check the performance counters.
module tb_inst_buffer_queue;
  import inst_buffer_queue_pkg::*;

  localparam int W     = DISPATCH_W;
  localparam int DEPTH = IBUFF_DEPTH;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             reset;
  logic             recoverFlag_i;
  logic             stall_i;
  ren_pkt_t [W-1:0] decPacket_i;
  logic [W-1:0]     decValid_i;
  ren_pkt_t [W-1:0] renPacket_o;
  logic             instBufferReady_o;
  logic             stallDecode_o;
  logic [AW:0]      ibuffCnt_o;
`ifdef IBUFF_PERF_EN
  logic [31:0]      fullCycles_o;
  logic [31:0]      starveCycles_o;
  int unsigned      full_exp;
  int unsigned      starve_exp;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: the buffered packets in arrival order.
  logic [PKT_W-1:0] exp_q[$];
  logic [7:0]       seq_ctr;

  inst_buffer_queue dut (
    .clk               (clk),
    .reset             (reset),
    .recoverFlag_i     (recoverFlag_i),
    .stall_i           (stall_i),
    .decPacket_i       (decPacket_i),
    .decValid_i        (decValid_i),
    .renPacket_o       (renPacket_o),
    .instBufferReady_o (instBufferReady_o),
    .stallDecode_o     (stallDecode_o),
    .ibuffCnt_o        (ibuffCnt_o)
`ifdef IBUFF_PERF_EN
    ,
    .fullCycles_o      (fullCycles_o),
    .starveCycles_o    (starveCycles_o)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_packets();
    for (int i = 0; i < W; i++) begin
      decPacket_i[i] = {1'($urandom), 8'(seq_ctr + 8'(i)), 32'($urandom)};
    end
  endtask

  // Compare every output against the model's current contents.
  task automatic check_outputs(input string ctx);
    int sz;
    sz = exp_q.size();
    check_eq({ctx, ".cnt"}, 64'(ibuffCnt_o), 64'(sz));
    check_eq({ctx, ".ready"}, 64'(instBufferReady_o), 64'(sz >= W));
    check_eq({ctx, ".stall_dec"}, 64'(stallDecode_o), 64'((DEPTH - sz) < W));
    for (int i = 0; i < W; i++) begin
      if (sz >= W)
        check_eq($sformatf("%s.lane%0d", ctx, i), 64'(renPacket_o[i]),
                 64'({1'b1, exp_q[i][PKT_W-2:0]}));
      else
        check_eq($sformatf("%s.lane%0d_valid", ctx, i), 64'(renPacket_o[i].valid), 64'(0));
    end
`ifdef IBUFF_PERF_EN
    check_eq({ctx, ".full_cycles"}, 64'(fullCycles_o), 64'(full_exp));
    check_eq({ctx, ".starve_cycles"}, 64'(starveCycles_o), 64'(starve_exp));
`endif
  endtask

  // Driver: called at a negedge; checks, drives one cycle, advances the
  // model and returns at the following negedge.
  task automatic step(input bit stl, input bit rec, input int n);
    int sz;
    bit m_ready;
    bit m_stall;
    check_outputs("step");
    sz      = exp_q.size();
    m_ready = (sz >= W);
    m_stall = ((DEPTH - sz) < W);
    if (m_stall) n = 0;
    stall_i       = stl;
    recoverFlag_i = rec;
    decValid_i    = W'((1 << n) - 1);
    randomize_packets();
`ifdef IBUFF_PERF_EN
    if (m_stall) full_exp++;
    if (!m_ready && !stl) starve_exp++;
`endif
    if (rec) begin
      exp_q.delete();
    end else begin
      if (m_ready && !stl) begin
        repeat (W) void'(exp_q.pop_front());
      end
      for (int i = 0; i < n; i++) exp_q.push_back(decPacket_i[i]);
      seq_ctr = seq_ctr + 8'(n);
    end
    @(negedge clk);
  endtask

  // Reset with a push, pop and recovery all offered at once; all discarded.
  task automatic do_reset();
    reset         = 1'b1;
    recoverFlag_i = 1'b1;
    stall_i       = 1'b0;
    decValid_i    = '1;
    randomize_packets();
    @(negedge clk);
    @(negedge clk);
    reset         = 1'b0;
    recoverFlag_i = 1'b0;
    decValid_i    = '0;
    exp_q.delete();
    seq_ctr = 8'd0;
`ifdef IBUFF_PERF_EN
    full_exp   = 0;
    starve_exp = 0;
`endif
  endtask

  initial begin
    seq_ctr = 8'd0;
    do_reset();

    // Reset state against constants.
    check_eq("rst.cnt", 64'(ibuffCnt_o), 64'(0));
    check_eq("rst.ready", 64'(instBufferReady_o), 64'(0));
    check_eq("rst.stall_dec", 64'(stallDecode_o), 64'(0));
    for (int i = 0; i < W; i++)
      check_eq($sformatf("rst.lane%0d_valid", i), 64'(renPacket_o[i].valid), 64'(0));

    // Two full pushes drain in order.
    step(0, 0, 4);
    check_eq("t1.ready", 64'(instBufferReady_o), 64'(1));
    for (int i = 0; i < W; i++)
      check_eq($sformatf("t1.seq%0d", i), 64'(renPacket_o[i].seq_no), 64'(i));
    step(0, 0, 4);
    for (int i = 0; i < W; i++)
      check_eq($sformatf("t1.seq%0d_b", i), 64'(renPacket_o[i].seq_no), 64'(4 + i));
    step(0, 0, 0);
    check_eq("t1.cnt_empty", 64'(ibuffCnt_o), 64'(0));

    // Partial pushes: 3 then 1.
    do_reset();
    step(0, 0, 3);
    check_eq("t2.cnt3", 64'(ibuffCnt_o), 64'(3));
    check_eq("t2.ready3", 64'(instBufferReady_o), 64'(0));
    step(0, 0, 1);
    check_eq("t2.ready4", 64'(instBufferReady_o), 64'(1));
    for (int i = 0; i < W; i++)
      check_eq($sformatf("t2.seq%0d", i), 64'(renPacket_o[i].seq_no), 64'(i));
    step(0, 0, 0);

    // Fill under stall until free space drops below W, then hold.
    do_reset();
    step(1, 0, 1);
    repeat (7) step(1, 0, 4);
    check_eq("t3.cnt29", 64'(ibuffCnt_o), 64'(29));
    check_eq("t3.stall_dec", 64'(stallDecode_o), 64'(1));
    repeat (10) step(1, 0, 4);
    check_eq("t3.cnt_hold", 64'(ibuffCnt_o), 64'(29));
`ifdef IBUFF_PERF_EN
    check_eq("t3.full10", 64'(fullCycles_o), 64'(10));
`endif

    // Write group straddling the last slot, then read back across it.
    do_reset();
    repeat (7) step(1, 0, 4);
    step(1, 0, 2);
    repeat (7) step(0, 0, 0);
    check_eq("t4.cnt2", 64'(ibuffCnt_o), 64'(2));
    step(1, 0, 4);
    step(0, 0, 0);
    step(0, 0, 2);
    check_eq("t4.cnt4", 64'(ibuffCnt_o), 64'(4));
    for (int i = 0; i < W; i++)
      check_eq($sformatf("t4.seq%0d", i), 64'(renPacket_o[i].seq_no), 64'(32 + i));
    step(0, 0, 0);

    // Recovery at count 12 with push and pop offered.
    do_reset();
    repeat (3) step(1, 0, 4);
    check_eq("t5.cnt12", 64'(ibuffCnt_o), 64'(12));
    step(0, 1, 4);
    check_eq("t5.cnt0", 64'(ibuffCnt_o), 64'(0));
    check_eq("t5.ready", 64'(instBufferReady_o), 64'(0));
    check_eq("t5.stall_dec", 64'(stallDecode_o), 64'(0));

    // Random traffic with varying stall pressure and occasional resets.
    for (int blk = 0; blk < 12; blk++) begin
      int stall_pct;
      stall_pct = (blk % 3 == 0) ? 70 : ((blk % 3 == 1) ? 25 : 5);
      if (blk % 4 == 3) do_reset();
      repeat (250) begin
        step($urandom_range(0, 99) < stall_pct,
             $urandom_range(0, 99) == 0,
             $urandom_range(0, W));
      end
    end
    check_outputs("final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/inst_buffer_queue.md
Name: inst_buffer_queue

Overview:
- Decoupling FIFO between decode and rename.
- Each cycle it accepts up to W decoded packets and holds them in a circular buffer.
- When at least W packets are buffered and rename is not stalled, it presents exactly W packets to rename with instBufferReady_o asserted.
- It flushes on recovery and backpressures decode when nearly full.

Parameters:
- W, 4, lanes per cycle in and out (tied to `DISPATCH_WIDTH).
- DEPTH, 32, entries; power of two, DEPTH >= 2*W.
- PKT_W, from package, bit width of one renPkt.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous active-high reset
- recoverFlag_i  in  1  flush all entries (branch mispredict or exception)
- stall_i  in  1  rename/backend stall; no dequeue this cycle
- decPacket_i  in  W x PKT_W  decoded packets, lane 0 first
- decValid_i  in  W  per-lane valid; must be contiguous from lane 0 (thermometer)
- renPacket_o  out  W x PKT_W  packets to rename
- instBufferReady_o  out  1  W packets valid on renPacket_o
- stallDecode_o  out  1  decode must hold; writes ignored
- ibuffCnt_o  out  log2(DEPTH)+1  current occupancy

Behaviour:
- State: head and tail pointers (log2(DEPTH) bits, wrap modulo DEPTH); count register (0..DEPTH); DEPTH x PKT_W storage array.
- Reset (synchronous): head=0, tail=0, count=0. Outputs: instBufferReady_o=0, stallDecode_o=0, ibuffCnt_o=0, renPacket_o[*].valid=0. Storage contents are don't-care.
- instBufferReady_o = (count >= W); combinational from registered count.
- renPacket_o[i] = entry[(head+i) mod DEPTH]. The valid field is forced to instBufferReady_o.
- Pop: when instBufferReady_o & ~stall_i, head += W and count -= W at the clock edge.
- stallDecode_o = (DEPTH - count) < W, using the registered count. It is conservative: a same-cycle pop does not release the stall.
- Push: when ~stallDecode_o, let n = popcount(decValid_i), 0..W.
  - Lane i is written to entry[(tail+i) mod DEPTH] for i < n.
  - tail += n.
- count_next = count + n − (pop ? W : 0). Simultaneous push and pop are legal.
- Writes while stallDecode_o=1 are dropped. Decode is required to hold them, and an assertion fires if decValid_i != 0 in that cycle.
- A non-thermometer decValid_i is illegal. Assert on it; only the count of lanes is honoured.
- Wrap-around: any W-group may straddle entry DEPTH-1 to entry 0. Index arithmetic truncates to log2(DEPTH) bits.
- recoverFlag_i has the highest priority:
  - Next cycle head=tail=count=0 and instBufferReady_o=0.
  - Any same-cycle push or pop is discarded.
- Reset overrides recoverFlag_i. Reset during a push or pop discards the push or pop.
- count never exceeds DEPTH or underflows. Verification asserts this.
- Latency: a packet pushed at cycle t is visible on renPacket_o at t+1, provided count >= W then.

Optional Feature:
- Macro IBUFF_PERF_EN.
- Defined:
  - Output fullCycles_o (32-bit) counts cycles with stallDecode_o=1.
  - Output starveCycles_o (32-bit) counts cycles with instBufferReady_o=0 & ~stall_i.
  - Both counters saturate at all-ones, clear on reset, and are not cleared by recovery.
- Undefined: the ports and counters are absent. Core behaviour is identical either way.

Decomposition:
- Shared package: renPkt typedef, `DISPATCH_WIDTH, IBUFF_DEPTH and its log2 constant.
- One natural sub-module, ibuff_ram: a DEPTH x PKT_W RAM with W write ports and W read ports, synchronous write and asynchronous read. It holds storage only; pointers and count stay in the parent.

Test Plan:
- Reset, then push 4 lanes/cycle for 2 cycles with stall_i=0 → instBufferReady_o=1 from cycle 2. Packets pop in order seqNo 0..3, then 4..7; count returns to 0.
- Push 3 lanes, then 1 lane → instBufferReady_o=0 after the first push (count=3). It is 1 after the second (count=4), with renPacket_o = seqNo 0..3.
- Hold stall_i=1 and push 4/cycle → stallDecode_o asserts at count=29 (free 3 < 4). count holds at 29; dropped-write assertion fires if decode ignores the stall.
- Wrap: with head=tail=30 and count=0, push 4 then pop → entries 30,31,0,1 return in order; head=2.
- recoverFlag_i at count=12 with simultaneous push and pop → next cycle count=0, instBufferReady_o=0, stallDecode_o=0.
- IBUFF_PERF_EN: 10 stalled-full cycles → fullCycles_o=10. With the macro undefined, compile with the ports absent.
